ram256x12_arbiter: RTL and testbench
====================================

Name: ram256x12_arbiter

Overview:
- Shares one RAM256X12 block (256 x 12, independent read and write ports, registered read data) between two clients.
- Client 0 is the display scan-out; client 1 is the draw engine.
- Read and write ports are arbitrated independently every cycle, so one read and one write can complete in the same cycle.
- Read data is returned through a 1-cycle tagged pipeline to the client that was granted the read.

Parameters:
- ARB_MODE, 0, selects arbitration policy: 0 = round-robin, 1 = fixed priority to client 0 with a starvation guard.
- STARVE_LIMIT, 4, ARB_MODE=1 only: number of consecutive denied cycles of client 1 on a port before client 1 is force-granted. Legal range 1..15.

Ports:
- i_clk  in  1  single clock, drives the arbiter and the RAM.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_rd_req  in  2  per-client read request; held until granted.
- i_rd_addr  in  2x8  per-client read address.
- o_rd_gnt  out  2  one-hot read grant; combinational, same cycle as the request.
- o_rd_valid  out  2  one-hot; high exactly 1 cycle after that client's read grant.
- o_rd_data  out  12  read data, meaningful only while any o_rd_valid bit is high.
- i_wr_req  in  2  per-client write request; held until granted.
- i_wr_addr  in  2x8  per-client write address.
- i_wr_data  in  2x12  per-client write data.
- o_wr_gnt  out  2  one-hot write grant; combinational.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous, active-low.
- Reset values:
  - o_rd_valid = 0, o_rd_data = 0.
  - Grants are forced to 0 while i_rst_n is low.
  - Round-robin pointers reset to "last granted = client 1".
  - Starvation counters reset to 0.
- Handshake:
  - A transfer occurs in a cycle where req and gnt are both high.
  - The client may change addr/data or drop req in the following cycle.
  - gnt never asserts without the matching req. At most one bit of each gnt vector is high.
- RAM drive:
  - RE = |o_rd_gnt, raddr = granted client's address.
  - WE = |o_wr_gnt, waddr/wdata = granted client's values.
  - Unused upper RAM bits are the RAM wrapper's concern.
- Read latency:
  - 1 cycle. A 1-bit owner tag plus a valid flag are registered on grant.
  - o_rd_valid = valid flag decoded by tag.
  - o_rd_data = RAM rdata when the valid flag is set, else 0.
- Round-robin (ARB_MODE=0):
  - Sole requester wins.
  - On conflict, the client not granted last on that port wins.
  - The pointer updates only on a grant.
- Fixed priority (ARB_MODE=1):
  - Client 0 wins conflicts.
  - Per-port 4-bit counter increments each cycle client 1 requests and is denied; it clears on any client-1 grant.
  - When the counter equals STARVE_LIMIT, client 1 wins the next conflict and the counter clears.
- Same-address read and write in one cycle: the read returns the old contents; the write lands. No bypass.
- Reset during operation: an in-flight read (granted the previous cycle) is dropped. No o_rd_valid is produced after reset deasserts for a request granted before reset.
- Requests are independent across ports. A client may hold a read grant and a write grant in the same cycle.

Decomposition:
- Package ram_arb_pkg:
  - constants NUM_CLIENTS=2, ADDR_W=8, DATA_W=12.
  - enum arb_mode_e {ARB_RR, ARB_FIXED}.
  - typedefs addr_t and data_t.
- Sub-module ram_arb_2way: one 2-requester arbiter containing the pointer, the starvation counter and the grant logic.
  - Instantiated twice, once for the read port and once for the write port.
  - The top level holds the valid/tag pipeline and the RAM256X12 instance.

Test Plan:
- Reset then single write: client 1 writes addr 0x10 = 0xABC, client 0 reads 0x10 next cycle -> o_wr_gnt=2'b10 in cycle 0; o_rd_gnt=2'b01 in cycle 1; o_rd_valid=2'b01 and o_rd_data=0xABC in cycle 2.
- RR conflict, ARB_MODE=0: both clients hold rd_req for 4 cycles at addrs 0x01/0x02 (preloaded 0x111/0x222) -> grants alternate 01,10,01,10; valid/data follow one cycle later with 0x111,0x222,0x111,0x222.
- Starvation, ARB_MODE=1, STARVE_LIMIT=4: both hold wr_req continuously -> client 0 granted 4 cycles, client 1 granted on the 5th, pattern repeats.
- Same-address collision: addr 0x40 holds 0x555; client 0 writes 0x0F0 while client 1 reads 0x40 in the same cycle -> client 1 receives 0x555; a read the following cycle returns 0x0F0.
- Reset mid-read: grant a read, assert i_rst_n low before the next edge -> o_rd_valid stays 0, o_rd_data=0, grants are 0 during reset; after release the first conflict goes to client 0.
- Random soak: constrained-random req/addr/data on both ports against a 256-entry scoreboard -> no double grants, grant only with req, every grant yields exactly one valid with the correct data.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared constants and types for the two-client RAM256X12 arbiter.
// Covers client count, address/data widths and the arbitration-mode enum.
package ram_arb_pkg;
    localparam int NUM_CLIENTS = 2;
    localparam int ADDR_W      = 8;
    localparam int DATA_W      = 12;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/RAM256X12.sv
// 256 x 12 RAM with independent read and write ports and registered read data.
// A same-address read and write in one cycle returns the old contents.
module RAM256X12
    import ram_arb_pkg::*;
(
    input  logic  clk,
    input  logic  re,
    input  addr_t raddr,
    output data_t rdata,
    input  logic  we,
    input  addr_t waddr,
    input  data_t wdata
);
    data_t mem [256];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/ram_arb_2way.sv
// Two-requester arbiter for one RAM port: round-robin, or fixed priority to
// client 0 with a starvation guard for client 1. Grants are combinational.
module ram_arb_2way
    import ram_arb_pkg::*;
#(
    parameter arb_mode_e ARB_MODE     = ARB_RR,
    parameter int        STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic       last_q;     // 1 = client 1 was granted last on this port
    logic [3:0] starve_q;
    logic       c1_wins;

    always_comb begin
        c1_wins = 1'b0;
        if (ARB_MODE == ARB_RR) c1_wins = ~last_q;
        else                    c1_wins = (starve_q == 4'(STARVE_LIMIT));

        gnt = 2'b00;
        if (rst_n) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = c1_wins ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q   <= 1'b1;
            starve_q <= '0;
        end else begin
            if (|gnt) last_q <= gnt[1];
            // Counter can never pass STARVE_LIMIT: at the limit client 1 always wins.
            if (ARB_MODE == ARB_FIXED) begin
                if (gnt[1])      starve_q <= '0;
                else if (req[1]) starve_q <= starve_q + 4'd1;
            end
        end
    end
endmodule

// File: rtl/ram256x12_arbiter.sv
// Shares one RAM256X12 between display scan-out (client 0) and draw engine
// (client 1); read and write ports are arbitrated independently every cycle.
module ram256x12_arbiter
    import ram_arb_pkg::*;
#(
    parameter arb_mode_e ARB_MODE     = ARB_RR,
    parameter int        STARVE_LIMIT = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic  [NUM_CLIENTS-1:0]       i_rd_req,
    input  addr_t [NUM_CLIENTS-1:0]       i_rd_addr,
    output logic  [NUM_CLIENTS-1:0]       o_rd_gnt,
    output logic  [NUM_CLIENTS-1:0]       o_rd_valid,
    output data_t                         o_rd_data,
    input  logic  [NUM_CLIENTS-1:0]       i_wr_req,
    input  addr_t [NUM_CLIENTS-1:0]       i_wr_addr,
    input  data_t [NUM_CLIENTS-1:0]       i_wr_data,
    output logic  [NUM_CLIENTS-1:0]       o_wr_gnt
);
    logic  ram_re, ram_we;
    addr_t ram_raddr, ram_waddr;
    data_t ram_wdata, ram_rdata;
    logic  rd_vld_q, rd_tag_q;

    ram_arb_2way #(.ARB_MODE(ARB_MODE), .STARVE_LIMIT(STARVE_LIMIT)) u_rd_arb (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .req   (i_rd_req),
        .gnt   (o_rd_gnt)
    );

    ram_arb_2way #(.ARB_MODE(ARB_MODE), .STARVE_LIMIT(STARVE_LIMIT)) u_wr_arb (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .req   (i_wr_req),
        .gnt   (o_wr_gnt)
    );

    assign ram_re    = |o_rd_gnt;
    assign ram_raddr = o_rd_gnt[1] ? i_rd_addr[1] : i_rd_addr[0];
    assign ram_we    = |o_wr_gnt;
    assign ram_waddr = o_wr_gnt[1] ? i_wr_addr[1] : i_wr_addr[0];
    assign ram_wdata = o_wr_gnt[1] ? i_wr_data[1] : i_wr_data[0];

    RAM256X12 u_ram (
        .clk   (i_clk),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata)
    );

    // Owner tag travels alongside the RAM's own read register; reset drops it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_vld_q <= 1'b0;
            rd_tag_q <= 1'b0;
        end else begin
            rd_vld_q <= ram_re;
            rd_tag_q <= o_rd_gnt[1];
        end
    end

    assign o_rd_valid = rd_vld_q ? (rd_tag_q ? 2'b10 : 2'b01) : 2'b00;
    assign o_rd_data  = rd_vld_q ? ram_rdata : '0;
endmodule

// File: tb/tb_ram256x12_arbiter.sv
// Bench for ram256x12_arbiter: a round-robin and a fixed-priority instance
// share stimulus; each is compared against its own behavioural model.
module tb_ram256x12_arbiter;
    import ram_arb_pkg::*;

    localparam int STARVE = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic  [1:0] rd_req = '0;
    addr_t [1:0] rd_addr = '0;
    logic  [1:0] wr_req = '0;
    addr_t [1:0] wr_addr = '0;
    data_t [1:0] wr_data = '0;

    logic  [1:0] rd_gnt_o   [2];
    logic  [1:0] rd_valid_o [2];
    data_t       rd_data_o  [2];
    logic  [1:0] wr_gnt_o   [2];

    int checks = 0;
    int errors = 0;

    // Model state, index m: 0 = round-robin instance, 1 = fixed-priority instance.
    int    last_win [2][2];   // [m][port] client granted last (port 0 = read, 1 = write)
    int    streak   [2][2];   // consecutive denied cycles of client 1
    data_t mem_m    [2][256];
    bit    known_m  [2][256];
    bit    pv       [2];
    int    ptag     [2];
    data_t pdata    [2];
    bit    pknown   [2];

    always #5 clk = ~clk;

    ram256x12_arbiter #(.ARB_MODE(ARB_RR), .STARVE_LIMIT(STARVE)) dut_rr (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_gnt(rd_gnt_o[0]),
        .o_rd_valid(rd_valid_o[0]), .o_rd_data(rd_data_o[0]),
        .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .o_wr_gnt(wr_gnt_o[0])
    );

    ram256x12_arbiter #(.ARB_MODE(ARB_FIXED), .STARVE_LIMIT(STARVE)) dut_fx (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_gnt(rd_gnt_o[1]),
        .o_rd_valid(rd_valid_o[1]), .o_rd_data(rd_data_o[1]),
        .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .o_wr_gnt(wr_gnt_o[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] model_gnt(input int m, input int p, input logic [1:0] req);
        int winner;
        if (req == 2'b00) return 2'b00;
        if (req == 2'b01) return 2'b01;
        if (req == 2'b10) return 2'b10;
        if (m == 0) winner = (last_win[m][p] == 0) ? 1 : 0;
        else        winner = (streak[m][p] >= STARVE) ? 1 : 0;
        return (winner == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int p = 0; p < 2; p++) begin
                last_win[m][p] = 1;
                streak[m][p]   = 0;
            end
            pv[m] = 1'b0;
        end
    endtask

    task automatic idle();
        rd_req = '0;
        wr_req = '0;
    endtask

    // Wait to the falling edge and compare every output of both instances.
    task automatic sample();
        logic [1:0] exp_v;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            check($sformatf("rd_gnt[%0d]", m), 32'(rd_gnt_o[m]), 32'(model_gnt(m, 0, rd_req)));
            check($sformatf("wr_gnt[%0d]", m), 32'(wr_gnt_o[m]), 32'(model_gnt(m, 1, wr_req)));
            exp_v = pv[m] ? ((ptag[m] == 1) ? 2'b10 : 2'b01) : 2'b00;
            check($sformatf("rd_valid[%0d]", m), 32'(rd_valid_o[m]), 32'(exp_v));
            if (pv[m] && pknown[m])
                check($sformatf("rd_data[%0d]", m), 32'(rd_data_o[m]), 32'(pdata[m]));
            else if (!pv[m])
                check($sformatf("rd_data_idle[%0d]", m), 32'(rd_data_o[m]), 32'd0);
        end
    endtask

    // Apply the effect of the coming rising edge to the models, then cross it.
    task automatic advance();
        logic [1:0] g [2];
        logic [1:0] r [2];
        int c;
        r[0] = rd_req;
        r[1] = wr_req;
        for (int m = 0; m < 2; m++) begin
            g[0] = model_gnt(m, 0, rd_req);
            g[1] = model_gnt(m, 1, wr_req);
            pv[m] = |g[0];
            if (|g[0]) begin
                c = int'(g[0][1]);
                ptag[m]   = c;
                pdata[m]  = mem_m[m][rd_addr[c]];
                pknown[m] = known_m[m][rd_addr[c]];
            end
            if (|g[1]) begin
                c = int'(g[1][1]);
                mem_m[m][wr_addr[c]]   = wr_data[c];
                known_m[m][wr_addr[c]] = 1'b1;
            end
            for (int p = 0; p < 2; p++) begin
                if (|g[p]) last_win[m][p] = int'(g[p][1]);
                if (g[p][1])     streak[m][p] = 0;
                else if (r[p][1]) streak[m][p] = streak[m][p] + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            check($sformatf("rst_valid[%0d]", m), 32'(rd_valid_o[m]), 32'd0);
            check($sformatf("rst_data[%0d]", m), 32'(rd_data_o[m]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            check($sformatf("init_valid[%0d]", m), 32'(rd_valid_o[m]), 32'd0);
            check($sformatf("init_data[%0d]", m), 32'(rd_data_o[m]), 32'd0);
            check($sformatf("init_rgnt[%0d]", m), 32'(rd_gnt_o[m]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single write by client 1, read back by client 0.
        wr_req = 2'b10; wr_addr[1] = 8'h10; wr_data[1] = 12'hABC;
        sample();
        check("t1_wr_gnt", 32'(wr_gnt_o[0]), 32'b10);
        advance();
        idle(); rd_req = 2'b01; rd_addr[0] = 8'h10;
        sample();
        check("t1_rd_gnt", 32'(rd_gnt_o[0]), 32'b01);
        advance();
        idle();
        sample();
        for (int m = 0; m < 2; m++) begin
            check("t1_rd_valid", 32'(rd_valid_o[m]), 32'b01);
            check("t1_rd_data", 32'(rd_data_o[m]), 32'hABC);
        end
        advance();

        // Round-robin read conflict on preloaded 0x01/0x02.
        wr_req = 2'b01; wr_addr[0] = 8'h01; wr_data[0] = 12'h111;
        sample(); advance();
        wr_req = 2'b10; wr_addr[1] = 8'h02; wr_data[1] = 12'h222;
        sample(); advance();
        do_reset();
        rd_req = 2'b11; rd_addr[0] = 8'h01; rd_addr[1] = 8'h02;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) idle();
            sample();
            if (i < 4)
                check("rr_gnt", 32'(rd_gnt_o[0]), (i % 2 == 1) ? 32'b10 : 32'b01);
            if (i > 0) begin
                check("rr_valid", 32'(rd_valid_o[0]), ((i - 1) % 2 == 1) ? 32'b10 : 32'b01);
                check("rr_data", 32'(rd_data_o[0]), ((i - 1) % 2 == 1) ? 32'h222 : 32'h111);
            end
            advance();
        end

        // Starvation guard on the write port of the fixed-priority instance.
        do_reset();
        wr_req = 2'b11;
        for (int i = 0; i < 10; i++) begin
            wr_addr[0] = 8'($urandom_range(128, 255));
            wr_addr[1] = 8'($urandom_range(128, 255));
            wr_data[0] = 12'($urandom);
            wr_data[1] = 12'($urandom);
            sample();
            check("starve_gnt", 32'(wr_gnt_o[1]), (i % 5 == 4) ? 32'b10 : 32'b01);
            advance();
        end
        idle();

        // Same-address read and write: old data first, new data next cycle.
        wr_req = 2'b01; wr_addr[0] = 8'h40; wr_data[0] = 12'h555;
        sample(); advance();
        wr_data[0] = 12'h0F0; rd_req = 2'b10; rd_addr[1] = 8'h40;
        sample(); advance();
        wr_req = 2'b00;
        sample();
        for (int m = 0; m < 2; m++) begin
            check("coll_valid", 32'(rd_valid_o[m]), 32'b10);
            check("coll_old", 32'(rd_data_o[m]), 32'h555);
        end
        advance();
        idle();
        sample();
        for (int m = 0; m < 2; m++) check("coll_new", 32'(rd_data_o[m]), 32'h0F0);
        advance();

        // Reset asserted between a read grant and its completing edge.
        rd_req = 2'b01; rd_addr[0] = 8'h40; wr_req = 2'b01;
        sample();
        check("mid_gnt", 32'(rd_gnt_o[0]), 32'b01);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int m = 0; m < 2; m++) begin
            check("mid_rst_rgnt", 32'(rd_gnt_o[m]), 32'd0);
            check("mid_rst_wgnt", 32'(wr_gnt_o[m]), 32'd0);
        end
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            check("mid_rst_valid", 32'(rd_valid_o[m]), 32'd0);
            check("mid_rst_data", 32'(rd_data_o[m]), 32'd0);
        end
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        sample();
        for (int m = 0; m < 2; m++) check("post_rst_valid", 32'(rd_valid_o[m]), 32'd0);
        advance();
        rd_req = 2'b11; rd_addr[1] = 8'h40;
        sample();
        for (int m = 0; m < 2; m++) check("post_rst_gnt", 32'(rd_gnt_o[m]), 32'b01);
        advance();
        idle();

        // Random soak over a small address window so reads hit written data.
        for (int i = 0; i < 400; i++) begin
            rd_req = 2'($urandom_range(0, 3));
            wr_req = 2'($urandom_range(0, 3));
            for (int c = 0; c < 2; c++) begin
                rd_addr[c] = 8'($urandom_range(0, 15));
                wr_addr[c] = 8'($urandom_range(0, 15));
                wr_data[c] = 12'($urandom);
            end
            sample();
            for (int m = 0; m < 2; m++) begin
                check("soak_rd_onehot", 32'($countones(rd_gnt_o[m]) <= 1), 32'd1);
                check("soak_rd_noreq", 32'(rd_gnt_o[m] & ~rd_req), 32'd0);
            end
            advance();
        end
        idle();
        sample();
        advance();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
